fft_test_sys_timer_multi: RTL and testbench



---
 rtl/fft_test_sys_timer_multi.sv | 149 ++++++++++++++
 tb/tb_fft_test_sys_timer_multi.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_test_sys_timer_multi.sv
// Multi-channel Avalon-MM interval timer: NUM_CH independent prescaled down-counters with timeout irqs.
// Latency: writes take effect on the next clk edge; readdata is registered (1 cycle after address).
// Backpressure: none; the slave accepts every access with no wait states.
//
// Ports:
//   clk, reset_n           system clock, asynchronous active-low reset
//   address                word address {channel, reg}
//   chipselect, write_n    write strobe = chipselect & ~write_n
//   writedata / readdata   32-bit data path; readdata follows address every cycle
//   irq_vec, irq           per-channel interrupt (TO & ITO) and their OR
module fft_test_sys_timer_multi #(
  parameter int NUM_CH       = 4,
  parameter int COUNTER_W    = 32,
  parameter int PRESCALE_W   = 16,
  parameter int RESET_PERIOD = 99999,
  localparam int CH_AW       = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CH_AW+2:0]  address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);

  localparam logic [COUNTER_W-1:0] RST_PERIOD = COUNTER_W'(RESET_PERIOD);

  logic             wr_en;
  logic [CH_AW-1:0] ch_sel;
  logic [2:0]       reg_sel;
  logic [31:0]      ch_rdata [NUM_CH];
  logic [31:0]      rd_next;

  assign wr_en   = chipselect & ~write_n;
  assign ch_sel  = address[CH_AW+2:3];
  assign reg_sel = address[2:0];

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    logic [COUNTER_W-1:0]  counter_q;
    logic [COUNTER_W-1:0]  period_q;
    logic [COUNTER_W-1:0]  snap_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] pcount_q;
    logic                  cont_q;
    logic                  ito_q;
    logic                  run_q;
    logic                  to_q;
    logic                  force_q;
    logic                  zero_q;

    logic sel, wr_status, wr_ctrl, wr_period, wr_snap, wr_pre;
    logic start, stop, tick, cnt_zero, to_evt;
    logic [31:0] rd;

    // Channel numbers at or above NUM_CH never match, so such writes are dropped.
    assign sel       = wr_en & (ch_sel == CH_AW'(i));
    assign wr_status = sel & (reg_sel == 3'd0);
    assign wr_ctrl   = sel & (reg_sel == 3'd1);
    assign wr_period = sel & (reg_sel == 3'd2);
    assign wr_snap   = sel & (reg_sel == 3'd3);
    assign wr_pre    = sel & (reg_sel == 3'd4);
    assign start     = wr_ctrl & writedata[2];
    assign stop      = wr_ctrl & writedata[3];
    assign tick      = run_q & (pcount_q == '0);
    assign cnt_zero  = (counter_q == '0);
    // Edge detect so a counter parked at zero (PERIOD = 0) raises only one event.
    assign to_evt    = cnt_zero & ~zero_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        counter_q  <= RST_PERIOD;
        period_q   <= RST_PERIOD;
        snap_q     <= '0;
        prescale_q <= '0;
        pcount_q   <= '0;
        cont_q     <= 1'b0;
        ito_q      <= 1'b0;
        run_q      <= 1'b0;
        to_q       <= 1'b0;
        force_q    <= 1'b0;
        zero_q     <= 1'b0;
      end else begin
        zero_q  <= cnt_zero;
        force_q <= wr_period;

        if (wr_period) period_q   <= writedata[COUNTER_W-1:0];
        if (wr_pre)    prescale_q <= writedata[PRESCALE_W-1:0];
        if (wr_snap)   snap_q     <= counter_q;
        if (wr_ctrl) begin
          cont_q <= writedata[1];
          ito_q  <= writedata[0];
        end

        // A timeout landing on a STATUS write must not be lost.
        if (to_evt)         to_q <= 1'b1;
        else if (wr_status) to_q <= 1'b0;

        // The cycle after a PERIOD write restarts the channel from the new period.
        if (force_q) begin
          counter_q <= period_q;
          pcount_q  <= prescale_q;
        end else if (tick) begin
          pcount_q  <= prescale_q;
          counter_q <= cnt_zero ? period_q : counter_q - 1'b1;
        end else if (run_q) begin
          pcount_q  <= pcount_q - 1'b1;
        end

        // START has priority over STOP, forced reload and one-shot completion.
        if (start)                          run_q <= 1'b1;
        else if (stop || force_q)           run_q <= 1'b0;
        else if (tick && cnt_zero && !cont_q) run_q <= 1'b0;
      end
    end

    always_comb begin
      rd = '0;
      case (reg_sel)
        3'd0:    rd[1:0]            = {run_q, to_q};
        3'd1:    rd[1:0]            = {cont_q, ito_q};
        3'd2:    rd[COUNTER_W-1:0]  = period_q;
        3'd3:    rd[COUNTER_W-1:0]  = snap_q;
        3'd4:    rd[PRESCALE_W-1:0] = prescale_q;
        default: rd = '0;
      endcase
    end

    assign ch_rdata[i] = rd;
    assign irq_vec[i]  = to_q & ito_q;
  end

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == CH_AW'(i)) rd_next = ch_rdata[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign irq = |irq_vec;

endmodule

// File: tb/tb_fft_test_sys_timer_multi.sv
// Directed bench for fft_test_sys_timer_multi: a default 4-channel instance and a
// 5-channel instance for out-of-range channel decoding. Inputs change on negedge,
// outputs are sampled on negedge.
module tb_fft_test_sys_timer_multi;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  irq_vec;

  logic [5:0]  b_address;
  logic        b_chipselect;
  logic        b_write_n;
  logic [31:0] b_writedata;
  logic [31:0] b_readdata;
  logic        b_irq;
  logic [4:0]  b_irq_vec;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  fft_test_sys_timer_multi u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_vec    (irq_vec)
  );

  fft_test_sys_timer_multi #(.NUM_CH(5)) u_dut5 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (b_address),
    .chipselect (b_chipselect),
    .write_n    (b_write_n),
    .writedata  (b_writedata),
    .readdata   (b_readdata),
    .irq        (b_irq),
    .irq_vec    (b_irq_vec)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Called at a negedge; the write happens on the following posedge, returns at the next negedge.
  task automatic bus_write(input logic [1:0] ch, input logic [2:0] rg, input logic [31:0] data);
    address    = {ch, rg};
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] ch, input logic [2:0] rg, output logic [31:0] data);
    address = {ch, rg};
    @(negedge clk);
    data = readdata;
  endtask

  task automatic b_write(input logic [2:0] ch, input logic [2:0] rg, input logic [31:0] data);
    b_address    = {ch, rg};
    b_writedata  = data;
    b_chipselect = 1'b1;
    b_write_n    = 1'b0;
    @(negedge clk);
    b_chipselect = 1'b0;
    b_write_n    = 1'b1;
  endtask

  task automatic b_read(input logic [2:0] ch, input logic [2:0] rg, output logic [31:0] data);
    b_address = {ch, rg};
    @(negedge clk);
    data = b_readdata;
  endtask

  typedef struct {
    logic [1:0]  ch;
    logic [2:0]  rg;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t tbl [10];

  initial begin
    logic [31:0] d;

    tbl[0] = '{2'd0, 3'd0, 32'd0};
    tbl[1] = '{2'd0, 3'd1, 32'd0};
    tbl[2] = '{2'd0, 3'd2, 32'd99999};
    tbl[3] = '{2'd0, 3'd3, 32'd0};
    tbl[4] = '{2'd0, 3'd4, 32'd0};
    tbl[5] = '{2'd0, 3'd5, 32'd0};
    tbl[6] = '{2'd0, 3'd6, 32'd0};
    tbl[7] = '{2'd0, 3'd7, 32'd0};
    tbl[8] = '{2'd3, 3'd2, 32'd99999};
    tbl[9] = '{2'd3, 3'd0, 32'd0};

    reset_n = 1'b0;
    address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    b_address = '0; b_chipselect = 1'b0; b_write_n = 1'b1; b_writedata = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    check("reset_readdata", readdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_irq_vec", {28'd0, irq_vec}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      bus_read(tbl[i].ch, tbl[i].rg, d);
      check($sformatf("reset_read ch%0d reg%0d", tbl[i].ch, tbl[i].rg), d, tbl[i].exp);
    end

    // ch2: one-shot, prescale 3, period 2, ITO off. START edge = E0.
    bus_write(2'd2, 3'd4, 32'd3);
    bus_write(2'd2, 3'd2, 32'd2);
    bus_write(2'd2, 3'd1, 32'h4);            // now at N1
    repeat (3) @(negedge clk);               // N4
    bus_write(2'd2, 3'd3, 32'd0);            // snapshot at E4 -> 2
    bus_read(2'd2, 3'd3, d);                 // N6
    check("ch2_snap_hold_4cyc", d, 32'd2);
    bus_write(2'd2, 3'd3, 32'd0);            // snapshot at E6 -> 1
    bus_read(2'd2, 3'd3, d);                 // N8
    check("ch2_snap_after_tick", d, 32'd1);
    bus_read(2'd2, 3'd0, d);                 // N9, state after E7
    check("ch2_status_running", d, 32'd2);
    repeat (2) @(negedge clk);               // N11
    bus_read(2'd2, 3'd0, d);                 // state after E10
    check("ch2_status_to_run", d, 32'd3);
    @(negedge clk);                          // N13
    bus_read(2'd2, 3'd0, d);                 // state after E12
    check("ch2_status_oneshot_done", d, 32'd1);
    bus_write(2'd2, 3'd3, 32'd0);            // snapshot at E14
    bus_read(2'd2, 3'd3, d);
    check("ch2_counter_holds_period", d, 32'd2);
    bus_read(2'd2, 3'd1, d);
    check("ch2_control_readback", d, 32'd0);
    check("ch2_irq_vec_masked", {28'd0, irq_vec}, 32'd0);
    check("ch2_irq_masked", {31'd0, irq}, 32'd0);

    // ch1: continuous, period 5, prescale 0, ITO on. START edge = E0.
    bus_write(2'd1, 3'd4, 32'd0);
    bus_write(2'd1, 3'd2, 32'd5);
    bus_write(2'd1, 3'd1, 32'h7);            // N1
    for (int k = 0; k < 6; k++) begin
      check($sformatf("ch1_irq_low_c%0d", k + 1), {31'd0, irq_vec[1]}, 32'd0);
      @(negedge clk);
    end
    check("ch1_irq_vec_rise", {28'd0, irq_vec}, 32'h2);   // N7
    check("ch1_irq_rise", {31'd0, irq}, 32'd1);
    bus_write(2'd1, 3'd0, 32'd0);            // clear at E7
    for (int k = 0; k < 5; k++) begin
      check($sformatf("ch1_irq_cleared_c%0d", k), {31'd0, irq_vec[1]}, 32'd0);
      @(negedge clk);
    end
    check("ch1_irq_reassert", {31'd0, irq_vec[1]}, 32'd1); // N13
    bus_write(2'd1, 3'd0, 32'd0);            // clear at E13
    check("ch1_irq_clear2", {31'd0, irq_vec[1]}, 32'd0);
    repeat (4) @(negedge clk);               // N18
    bus_write(2'd1, 3'd0, 32'd0);            // clear on the event cycle
    check("ch1_set_beats_clear", {31'd0, irq_vec[1]}, 32'd1);
    bus_write(2'd1, 3'd1, 32'hB);            // STOP
    bus_read(2'd1, 3'd0, d);
    check("ch1_stop_status", d, 32'd1);
    bus_write(2'd1, 3'd1, 32'hF);            // START|STOP
    bus_read(2'd1, 3'd0, d);
    check("ch1_start_beats_stop", d, 32'd3);

    // ch0: continuous, period 50; snapshot while counter = 40.
    bus_write(2'd0, 3'd2, 32'd50);
    bus_write(2'd0, 3'd1, 32'h6);            // N1
    repeat (10) @(negedge clk);              // N11
    bus_write(2'd0, 3'd3, 32'd0);            // E11 captures 40
    bus_read(2'd0, 3'd3, d);
    check("ch0_snapshot_40", d, 32'd40);
    bus_write(2'd0, 3'd2, 32'd77);
    @(negedge clk);
    bus_read(2'd0, 3'd0, d);
    check("ch0_period_write_stops", d, 32'd0);
    bus_write(2'd0, 3'd3, 32'd0);
    bus_read(2'd0, 3'd3, d);
    check("ch0_force_reload_value", d, 32'd77);
    bus_read(2'd0, 3'd2, d);
    check("ch0_period_readback", d, 32'd77);
    check("irq_from_ch1", {31'd0, irq}, 32'd1);

    // Five-channel instance: channel 5 is out of range.
    b_write(3'd4, 3'd2, 32'd9);
    b_write(3'd5, 3'd2, 32'd7);
    b_write(3'd5, 3'd1, 32'h7);
    b_write(3'd5, 3'd4, 32'd1);
    b_read(3'd5, 3'd2, d);
    check("ch5_period_reads0", d, 32'd0);
    b_read(3'd5, 3'd1, d);
    check("ch5_control_reads0", d, 32'd0);
    b_read(3'd1, 3'd2, d);
    check("ch5_no_alias_ch1_period", d, 32'd99999);
    b_read(3'd1, 3'd0, d);
    check("ch5_no_alias_ch1_status", d, 32'd0);
    b_read(3'd0, 3'd4, d);
    check("ch5_no_alias_ch0_prescale", d, 32'd0);
    repeat (20) @(negedge clk);
    check("ch5_no_irq", {27'd0, b_irq_vec}, 32'd0);
    b_read(3'd4, 3'd2, d);
    check("ch4_valid_write", d, 32'd9);

    // Asynchronous reset mid-count.
    bus_read(2'd0, 3'd2, d);
    check("pre_reset_readdata", d, 32'd77);
    check("pre_reset_irq", {31'd0, irq}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_readdata", readdata, 32'd0);
    check("async_reset_irq", {31'd0, irq}, 32'd0);
    check("async_reset_irq_vec", {28'd0, irq_vec}, 32'd0);
    check("async_reset_b_readdata", b_readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    bus_read(2'd1, 3'd0, d);
    check("post_reset_ch1_status", d, 32'd0);
    bus_read(2'd0, 3'd2, d);
    check("post_reset_ch0_period", d, 32'd99999);
    repeat (5) @(negedge clk);
    bus_write(2'd1, 3'd3, 32'd0);
    bus_read(2'd1, 3'd3, d);
    check("post_reset_ch1_not_counting", d, 32'd99999);
    check("post_reset_irq", {31'd0, irq}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
